cbus_to_axi_bridge: RTL and testbench

Converts the single CBus master port leaving the CPU top (already arbitrated between I-cache and D-cache, physical address) into an AXI3 master interface for the SoC interconnect. Handles one transaction at a time: single or INCR bursts of up to 16 beats, reads and writes. Sits directly downstream of the CPU top's `oreq`/`oresp` port.

---
 rtl/cbus_to_axi_bridge_if.sv | 109 ++++++++++
 rtl/cbus_to_axi_bridge.sv | 161 ++++++++++++++++
 tb/tb_cbus_to_axi_bridge.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_to_axi_bridge_if.sv
// Bundle of every signal between the CBus/AXI bridge and its neighbours.
// Bundle contents:
//   creq   CBus request from the CPU top (valid, is_write, size, addr,
//          strobe, data, len = beats-1).
//   cresp  CBus response back to the CPU top (ready, last, data).
//   AR/R, AW/W/B  AXI3 master channels toward the SoC interconnect,
//          including constant lock/cache/prot sideband fields.
// Modports:
//   master  the bridge's view: drives AXI master signals and cresp.
//   slave   the environment's view: drives creq and AXI slave responses.

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

interface cbus_to_axi_bridge_if #(parameter int ID_WIDTH = 4);
  import cbus_pkg::*;

  cbus_req_t           creq;
  cbus_resp_t          cresp;

  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [ID_WIDTH-1:0] wid;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    input  creq,
    output cresp,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output creq,
    input  cresp,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cbus_to_axi_bridge.sv
// Converts the CPU top's single CBus master port into an AXI3 master.
// One transaction at a time: single beats or INCR bursts of up to 16
// beats, reads and writes. Write completion is reported only after the B
// response, so a following request never overtakes an accepted write.
// Ports:
//   i_clk     system clock
//   i_resetn  synchronous active-low reset
//   bus       cbus_to_axi_bridge_if.master: creq in, cresp out, AXI3
//             master channels AR/R/AW/W/B.

module cbus_to_axi_bridge #(
  parameter int ID_WIDTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  cbus_to_axi_bridge_if.master        bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } state_t;

  state_t     r_state;
  logic [3:0] r_count;
  logic       r_arvalid;
  logic       r_rready;
  logic       r_awvalid;
  logic       r_wvalid;
  logic       r_bready;

  logic       w_lastBeat;
  logic       w_unused;

  // The request fields are held stable by the master, so the beat counter
  // is compared directly against the live burst length.
  assign w_lastBeat = (r_count == bus.creq.len);

  // Transaction sequencer. Every valid/ready toward AXI is a registered
  // flag set on entry to its state and cleared on the handshake that
  // leaves it, so no valid ever depends combinationally on a ready.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state   <= ST_IDLE;
      r_count   <= 4'd0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_count <= 4'd0;
          if (bus.creq.valid) begin
            if (bus.creq.is_write) begin
              r_state   <= ST_AW;
              r_awvalid <= 1'b1;
            end else begin
              r_state   <= ST_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (bus.arready) begin
            r_state   <= ST_R;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        ST_R: begin
          if (bus.rvalid && bus.rlast) begin
            r_state  <= ST_IDLE;
            r_rready <= 1'b0;
          end
        end
        ST_AW: begin
          if (bus.awready) begin
            r_state   <= ST_W;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
          end
        end
        ST_W: begin
          if (bus.wready) begin
            if (w_lastBeat) begin
              r_state  <= ST_B;
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
            end else begin
              r_count <= r_count + 4'd1;
            end
          end
        end
        ST_B: begin
          if (bus.bvalid) begin
            r_state  <= ST_IDLE;
            r_bready <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Address and write-data payloads pass straight through from the held
  // request, but are forced to zero whenever their channel is not valid so
  // the AXI side is fully quiet in idle and right after reset.
  assign bus.arid    = {ID_WIDTH{1'b0}};
  assign bus.araddr  = r_arvalid ? bus.creq.addr : 32'd0;
  assign bus.arlen   = r_arvalid ? bus.creq.len  : 4'd0;
  assign bus.arsize  = r_arvalid ? bus.creq.size : 3'd0;
  assign bus.arburst = r_arvalid ? 2'b01 : 2'b00;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = r_arvalid;
  assign bus.rready  = r_rready;

  assign bus.awid    = {ID_WIDTH{1'b0}};
  assign bus.awaddr  = r_awvalid ? bus.creq.addr : 32'd0;
  assign bus.awlen   = r_awvalid ? bus.creq.len  : 4'd0;
  assign bus.awsize  = r_awvalid ? bus.creq.size : 3'd0;
  assign bus.awburst = r_awvalid ? 2'b01 : 2'b00;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'b0000;
  assign bus.awprot  = 3'b000;
  assign bus.awvalid = r_awvalid;

  assign bus.wid     = {ID_WIDTH{1'b0}};
  assign bus.wdata   = r_wvalid ? bus.creq.data   : 32'd0;
  assign bus.wstrb   = r_wvalid ? bus.creq.strobe : 4'd0;
  assign bus.wlast   = r_wvalid & w_lastBeat;
  assign bus.wvalid  = r_wvalid;
  assign bus.bready  = r_bready;

  // CBus response. Read beats are forwarded as they arrive. Non-final
  // write beats are acknowledged on wready so the master advances its
  // data; the final beat is acknowledged only once B arrives, which keeps
  // the last data stable and makes completion mean "globally accepted".
  always_comb begin
    bus.cresp       = '0;
    bus.cresp.ready = (r_rready & bus.rvalid)
                    | (r_wvalid & bus.wready & ~w_lastBeat)
                    | (r_bready & bus.bvalid);
    bus.cresp.last  = (r_rready & bus.rvalid & bus.rlast)
                    | (r_bready & bus.bvalid);
    bus.cresp.data  = r_rready ? bus.rdata : 32'd0;
  end

  // Response IDs and error codes carry no information for this bridge.
  assign w_unused = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};

endmodule

// File: tb/tb_cbus_to_axi_bridge.sv
// Self-checking bench for cbus_to_axi_bridge. The bench plays both the
// CBus master and a randomly stalling AXI slave, and predicts every
// observable value at transaction level: expected payload per beat kept
// in queues, expected address-phase fields taken from the request, and
// the CBus handshake rules (read beats acknowledged as they arrive,
// write beats acknowledged except the last, completion only on B).

module tb_cbus_to_axi_bridge;

  logic clk = 1'b0;
  logic resetn;
  int   checkCount = 0;
  int   errorCount = 0;

  always #5 clk = ~clk;

  cbus_to_axi_bridge_if #(.ID_WIDTH(4)) bus ();

  cbus_to_axi_bridge #(.ID_WIDTH(4)) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus.master)
  );

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Slave-side inputs at rest; IDs and error codes are randomised because
  // the bridge must ignore them.
  task automatic idleInputs();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.rdata   = $urandom;
    bus.rid     = 4'($urandom);
    bus.rresp   = 2'($urandom);
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bid     = 4'($urandom);
    bus.bresp   = 2'($urandom);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".arvalid"}, 32'(bus.arvalid), 32'd0);
    checkOutput({tag, ".awvalid"}, 32'(bus.awvalid), 32'd0);
    checkOutput({tag, ".wvalid"},  32'(bus.wvalid),  32'd0);
    checkOutput({tag, ".rready"},  32'(bus.rready),  32'd0);
    checkOutput({tag, ".bready"},  32'(bus.bready),  32'd0);
    checkOutput({tag, ".crready"}, 32'(bus.cresp.ready), 32'd0);
    checkOutput({tag, ".crlast"},  32'(bus.cresp.last),  32'd0);
  endtask

  // One idle cycle with the master's valid low.
  task automatic idleCycle();
    @(negedge clk);
    bus.creq.valid = 1'b0;
    idleInputs();
    #1;
    checkQuiet("idle");
    checkOutput("idle.araddr", bus.araddr, 32'd0);
  endtask

  // Read transaction. rMode: 0 random rvalid, 1 toggling, 2 always valid.
  // resetAtBeat >= 0 pulls reset while waiting for that beat.
  task automatic runRead(input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] len, input int arWait,
                         input int rMode, input logic [31:0] seedData,
                         input int resetAtBeat);
    logic [31:0] expData[$];
    int          beat;
    int          cyc;
    int          readyCount;
    int          lastCount;
    logic        rv;
    for (int i = 0; i <= int'(len); i++)
      expData.push_back((seedData != 0) ? seedData + 32'(i) : $urandom);
    @(negedge clk);
    bus.creq.valid    = 1'b1;
    bus.creq.is_write = 1'b0;
    bus.creq.addr     = addr;
    bus.creq.size     = size;
    bus.creq.len      = len;
    bus.creq.strobe   = 4'($urandom);
    bus.creq.data     = $urandom;
    idleInputs();
    #1;
    checkQuiet("rd.req");
    for (int w = 0; w <= arWait; w++) begin
      @(negedge clk);
      idleInputs();
      bus.arready = (w == arWait);
      #1;
      checkOutput("rd.arvalid", 32'(bus.arvalid), 32'd1);
      checkOutput("rd.araddr",  bus.araddr, addr);
      checkOutput("rd.arlen",   32'(bus.arlen), 32'(len));
      checkOutput("rd.arsize",  32'(bus.arsize), 32'(size));
      checkOutput("rd.arburst", 32'(bus.arburst), 32'd1);
      checkOutput("rd.awvalid", 32'(bus.awvalid), 32'd0);
      checkOutput("rd.arready.crready", 32'(bus.cresp.ready), 32'd0);
    end
    beat = 0;
    cyc = 0;
    readyCount = 0;
    lastCount = 0;
    while (beat <= int'(len)) begin
      @(negedge clk);
      idleInputs();
      if (beat == resetAtBeat) begin
        resetn = 1'b0;
        bus.creq.valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkQuiet("rd.rst");
        checkOutput("rd.rst.araddr", bus.araddr, 32'd0);
        checkOutput("rd.rst.crdata", bus.cresp.data, 32'd0);
        return;
      end
      case (rMode)
        1:       rv = (cyc % 2) == 1;
        2:       rv = 1'b1;
        default: rv = ($urandom_range(0, 1) == 1) || (cyc % 4 == 3);
      endcase
      bus.rvalid = rv;
      bus.rlast  = rv && (beat == int'(len));
      if (rv) bus.rdata = expData[beat];
      #1;
      checkOutput("rd.rready",  32'(bus.rready), 32'd1);
      checkOutput("rd.arvalid.inR", 32'(bus.arvalid), 32'd0);
      checkOutput("rd.crready", 32'(bus.cresp.ready), 32'(rv));
      checkOutput("rd.crlast",  32'(bus.cresp.last), 32'(rv && beat == int'(len)));
      if (rv) checkOutput("rd.crdata", bus.cresp.data, expData[beat]);
      readyCount += int'(bus.cresp.ready);
      lastCount  += int'(bus.cresp.last);
      if (rv) beat++;
      cyc++;
    end
    checkOutput("rd.readyPulses", 32'(readyCount), 32'(int'(len) + 1));
    checkOutput("rd.lastPulses",  32'(lastCount), 32'd1);
    @(posedge clk);
  endtask

  // Write transaction. wMode: 0 random wready, 1 always ready.
  task automatic runWrite(input logic [31:0] addr, input logic [2:0] size,
                          input logic [3:0] len, input logic [3:0] strobe,
                          input int awWait, input int wMode, input int bWait);
    logic [31:0] expData[$];
    int          beat;
    int          cyc;
    int          readyCount;
    logic        wr;
    logic        done;
    for (int i = 0; i <= int'(len); i++) expData.push_back($urandom);
    @(negedge clk);
    bus.creq.valid    = 1'b1;
    bus.creq.is_write = 1'b1;
    bus.creq.addr     = addr;
    bus.creq.size     = size;
    bus.creq.len      = len;
    bus.creq.strobe   = strobe;
    bus.creq.data     = expData[0];
    idleInputs();
    #1;
    checkQuiet("wr.req");
    for (int w = 0; w <= awWait; w++) begin
      @(negedge clk);
      idleInputs();
      bus.awready = (w == awWait);
      #1;
      checkOutput("wr.awvalid", 32'(bus.awvalid), 32'd1);
      checkOutput("wr.awaddr",  bus.awaddr, addr);
      checkOutput("wr.awlen",   32'(bus.awlen), 32'(len));
      checkOutput("wr.awsize",  32'(bus.awsize), 32'(size));
      checkOutput("wr.awburst", 32'(bus.awburst), 32'd1);
      checkOutput("wr.wvalid.inAW", 32'(bus.wvalid), 32'd0);
      checkOutput("wr.arvalid.inAW", 32'(bus.arvalid), 32'd0);
    end
    beat = 0;
    cyc = 0;
    readyCount = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      idleInputs();
      bus.creq.data = expData[beat];
      wr = (wMode == 1) || ($urandom_range(0, 1) == 1) || (cyc % 4 == 3);
      bus.wready = wr;
      #1;
      checkOutput("wr.wvalid", 32'(bus.wvalid), 32'd1);
      checkOutput("wr.wdata",  bus.wdata, expData[beat]);
      checkOutput("wr.wstrb",  32'(bus.wstrb), 32'(strobe));
      checkOutput("wr.wlast",  32'(bus.wlast), 32'(beat == int'(len)));
      checkOutput("wr.awvalid.inW", 32'(bus.awvalid), 32'd0);
      checkOutput("wr.crready", 32'(bus.cresp.ready), 32'(wr && beat != int'(len)));
      checkOutput("wr.crlast",  32'(bus.cresp.last), 32'd0);
      readyCount += int'(bus.cresp.ready);
      if (wr) begin
        if (beat == int'(len)) done = 1'b1;
        else beat++;
      end
      cyc++;
    end
    for (int b = 0; b <= bWait; b++) begin
      @(negedge clk);
      idleInputs();
      bus.bvalid = (b == bWait);
      #1;
      checkOutput("wr.bready",  32'(bus.bready), 32'd1);
      checkOutput("wr.wvalid.inB", 32'(bus.wvalid), 32'd0);
      checkOutput("wr.arvalid.inB", 32'(bus.arvalid), 32'd0);
      checkOutput("wr.b.crready", 32'(bus.cresp.ready), 32'(b == bWait));
      checkOutput("wr.b.crlast",  32'(bus.cresp.last), 32'(b == bWait));
      readyCount += int'(bus.cresp.ready);
    end
    checkOutput("wr.readyPulses", 32'(readyCount), 32'(int'(len) + 1));
    @(posedge clk);
  endtask

  // Picks one random transaction, optionally preceded by idle cycles.
  task automatic applyStimulus();
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) idleCycle();
    if ($urandom_range(0, 1) == 1)
      runWrite($urandom, 3'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
               4'($urandom), $urandom_range(0, 3), 0, $urandom_range(0, 3));
    else
      runRead($urandom, 3'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), 0, 32'd0, -1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus.creq = '0;
    idleInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkQuiet("reset");
    checkOutput("reset.araddr", bus.araddr, 32'd0);
    checkOutput("reset.crdata", bus.cresp.data, 32'd0);
    resetn = 1'b1;

    $display("[TB] directed transactions");
    runRead(32'h1fc0_0000, 3'd2, 4'd0, 2, 2, 32'hdeadbeef, -1);
    runRead(32'h8000_0040, 3'd2, 4'd15, 0, 1, 32'd0, -1);
    runWrite(32'h8000_1000, 3'd2, 4'd3, 4'hf, 1, 0, 2);
    runWrite(32'h0000_0101, 3'd0, 4'd0, 4'b0010, 0, 1, 0);
    runRead(32'h8000_2000, 3'd2, 4'd1, 0, 2, 32'd0, -1);
    runRead(32'h8000_3000, 3'd2, 4'd7, 1, 2, 32'd0, 3);
    runWrite(32'h8000_4000, 3'd2, 4'd2, 4'hf, 0, 1, 0);

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) applyStimulus();
    idleCycle();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
